minitb_ahb_arbiter: RTL and testbench

MINITB_AHB_ARBITER -- requirements
Module: minitb_ahb_arbiter

---
 rtl/minitb_ahb_pkg.sv | 32 +++
 rtl/minitb_ahb_arbiter_if.sv | 38 +++
 rtl/minitb_rr_picker.sv | 43 ++++
 rtl/minitb_ahb_arbiter.sv | 122 ++++++++++++
 tb/tb_minitb_ahb_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/minitb_ahb_pkg.sv
// ----------------------------------------------------------------------------
// minitb_ahb_pkg
//   Shared AHB definitions used by the arbiter slice:
//     - htrans_t    : address-phase transfer type encodings
//     - ST_* / arb_state_t : arbiter FSM state constants and their enum
//     - idx_width() : width of an index into an n-entry vector (at least 1)
// ----------------------------------------------------------------------------
package minitb_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    // Raw state codes, kept for code that compares against plain vectors.
    localparam logic [1:0] ST_PARK = 2'd0;
    localparam logic [1:0] ST_OWN  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    typedef enum logic [1:0] {
        ARB_PARK = ST_PARK,  // default master parked, nobody requesting
        ARB_OWN  = ST_OWN,   // a requester owns the bus
        ARB_LOCK = ST_LOCK   // grantee is holding hlock
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/minitb_ahb_arbiter_if.sv
// ----------------------------------------------------------------------------
// minitb_ahb_arbiter_if
//   Arbitration signals between the AHB requesters and the arbiter.
//     hbusreq   [NUM_MASTERS] per-master bus request
//     hlock     [NUM_MASTERS] per-master locked-transfer request
//     hready                  shared transfer-done / arbitration opportunity
//     htrans    [2]           address-phase transfer type of current owner
//     hgrant    [NUM_MASTERS] one-hot grant
//     hmaster                 index of the address-phase owner
//     hmastlock               current address phase is locked
//   Modports: slave  = arbiter side, master = requester side.
// ----------------------------------------------------------------------------
interface minitb_ahb_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    import minitb_ahb_pkg::*;

    localparam int MW = idx_width(NUM_MASTERS);

    logic [NUM_MASTERS-1:0] hbusreq;
    logic [NUM_MASTERS-1:0] hlock;
    logic                   hready;
    htrans_t                htrans;
    logic [NUM_MASTERS-1:0] hgrant;
    logic [MW-1:0]          hmaster;
    logic                   hmastlock;

    modport slave (
        input  hbusreq, hlock, hready, htrans,
        output hgrant, hmaster, hmastlock
    );

    modport master (
        output hbusreq, hlock, hready, htrans,
        input  hgrant, hmaster, hmastlock
    );

endinterface

// File: rtl/minitb_rr_picker.sv
// ----------------------------------------------------------------------------
// minitb_rr_picker
//   Combinational round-robin winner selection.
//     req   [N]  request vector
//     ptr        index of the last grantee; search starts at ptr+1 (mod N)
//     win   [N]  one-hot winner (all zero when nobody requests)
//     valid      at least one request was found
// ----------------------------------------------------------------------------
module minitb_rr_picker
    import minitb_ahb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            req,
    input  logic [idx_width(N)-1:0] ptr,
    output logic [N-1:0]            win,
    output logic                    valid
);

    // Distance of a requester from the search start; the closest wins.
    int best;
    int best_d;

    // NOTE: every variable written here gets a default first, otherwise
    // paths that skip an assignment would infer a latch.
    always_comb begin
        best   = 0;
        best_d = N;
        valid  = 1'b0;
        win    = '0;
        for (int j = 0; j < N; j++) begin
            if (req[j] && (((j - int'(ptr) - 1 + 2 * N) % N) < best_d)) begin
                best_d = (j - int'(ptr) - 1 + 2 * N) % N;
                best   = j;
                valid  = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            win[j] = valid && (best == j);
        end
    end

endmodule

// File: rtl/minitb_ahb_arbiter.sv
// ----------------------------------------------------------------------------
// minitb_ahb_arbiter
//   Round-robin AHB bus arbiter with tenure limit, parking and optional lock.
//     hclk    clock, all logic on the rising edge
//     hreset  synchronous active-high reset
//     bus     minitb_ahb_arbiter_if.slave: hbusreq, hlock, hready, htrans in;
//             hgrant (one-hot, registered), hmaster, hmastlock out
//   Parameters: NUM_MASTERS (2..16), DEFAULT_MASTER (parked master),
//               MAX_TENURE (2..256 hready-qualified cycles per grant).
//   Build option: define MINITB_AHB_ARB_LOCK_EN to honour hlock (LOCK state,
//   hmastlock). Without it hlock is ignored and hmastlock is tied low.
// ----------------------------------------------------------------------------
module minitb_ahb_arbiter
    import minitb_ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = 0,
    parameter int MAX_TENURE     = 16
) (
    input logic                  hclk,
    input logic                  hreset,
    minitb_ahb_arbiter_if.slave  bus
);

    localparam int W  = idx_width(NUM_MASTERS);
    localparam int TW = idx_width(MAX_TENURE);

    localparam logic [TW-1:0]          TEN_LAST = TW'(MAX_TENURE - 1);
    localparam logic [W-1:0]           DEF_IDX  = W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_OH   = NUM_MASTERS'(1) << DEFAULT_MASTER;

    arb_state_t             state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    // Index of the current grantee; doubles as the round-robin pointer.
    logic [W-1:0]           grant_idx_q;
    logic [W-1:0]           hmaster_q;
    logic                   hmastlock_q;
    logic [TW-1:0]          tenure_q;

    logic [NUM_MASTERS-1:0] win_oh;
    logic                   win_valid;
    logic [W-1:0]           win_idx;
    logic [TW-1:0]          tenure_inc;
    logic                   grantee_req;
    logic                   grantee_lock;
    logic                   lock_hold;
    logic                   tenure_hold;
    logic                   held;
    logic                   lock_enter;

`ifdef MINITB_AHB_ARB_LOCK_EN
    assign grantee_lock = bus.hlock[grant_idx_q];
`else
    logic unused_hlock;
    assign unused_hlock = ^bus.hlock;
    assign grantee_lock = 1'b0;
`endif

    minitb_rr_picker #(.N(NUM_MASTERS)) u_picker (
        .req   (bus.hbusreq),
        .ptr   (grant_idx_q),
        .win   (win_oh),
        .valid (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (win_oh[i]) win_idx = W'(i);
        end
    end

    assign tenure_inc  = (tenure_q == TEN_LAST) ? tenure_q : tenure_q + TW'(1);
    assign grantee_req = bus.hbusreq[grant_idx_q];

    // A parked grant is not a tenure, so a new request is served at once.
    assign lock_hold   = (state_q == ARB_LOCK) && grantee_lock;
    assign tenure_hold = (state_q != ARB_PARK) && grantee_req && (tenure_q < TEN_LAST);
    assign held        = lock_hold || tenure_hold || (bus.htrans == HTRANS_BUSY);
    assign lock_enter  = !held && grantee_lock;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= ARB_PARK;
            grant_q     <= DEF_OH;
            grant_idx_q <= DEF_IDX;
            hmaster_q   <= DEF_IDX;
            hmastlock_q <= 1'b0;
            tenure_q    <= '0;
        end else if (bus.hready) begin
            // Address phase follows the grant by one hready edge.
            hmaster_q   <= grant_idx_q;
            hmastlock_q <= grantee_lock;

            if (held) begin
                tenure_q <= tenure_inc;
                if (state_q == ARB_LOCK && !lock_hold) state_q <= ARB_OWN;
            end else if (lock_enter) begin
                state_q  <= ARB_LOCK;
                tenure_q <= tenure_inc;
            end else if (win_valid) begin
                // Fresh tenure even when the sole requester wins again.
                state_q     <= ARB_OWN;
                grant_q     <= win_oh;
                grant_idx_q <= win_idx;
                tenure_q    <= '0;
            end else begin
                state_q     <= ARB_PARK;
                grant_q     <= DEF_OH;
                grant_idx_q <= DEF_IDX;
                tenure_q    <= (grant_idx_q == DEF_IDX) ? tenure_inc : '0;
            end
        end
    end

    assign bus.hgrant    = grant_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = hmastlock_q;

endmodule

// File: tb/tb_minitb_ahb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_minitb_ahb_arbiter
//   Self-checking bench: directed scenarios with literal expectations plus a
//   randomized run, all compared every cycle against a behavioural model.
//   Honours MINITB_AHB_ARB_LOCK_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_minitb_ahb_arbiter;
    import minitb_ahb_pkg::*;

    localparam int N    = 4;
    localparam int DEF  = 0;
    localparam int MAXT = 4;

`ifdef MINITB_AHB_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic hclk = 1'b0;
    logic hreset;

    always #5 hclk = ~hclk;

    minitb_ahb_arbiter_if #(.NUM_MASTERS(N)) bus ();

    minitb_ahb_arbiter #(
        .NUM_MASTERS    (N),
        .DEFAULT_MASTER (DEF),
        .MAX_TENURE     (MAXT)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: who owns the bus, for how long, and why.
    // ------------------------------------------------------------------
    int m_owner    = DEF;
    int m_tenure   = 0;
    int m_hmaster  = DEF;
    bit m_parked   = 1'b1;
    bit m_locked   = 1'b0;
    bit m_hmastlock = 1'b0;

    function automatic int rr_next(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            if (req[(last + i) % N]) return (last + i) % N;
        end
        return DEF;
    endfunction

    function automatic int sat_inc(input int t);
        return (t + 1 > MAXT - 1) ? MAXT - 1 : t + 1;
    endfunction

    always @(posedge hclk) begin
        bit owner_lock;
        bit keep;
        if (hreset) begin
            m_owner = DEF; m_tenure = 0; m_parked = 1'b1; m_locked = 1'b0;
            m_hmaster = DEF; m_hmastlock = 1'b0;
        end else if (bus.hready) begin
            owner_lock  = LOCK_EN && bus.hlock[m_owner];
            m_hmaster   = m_owner;
            m_hmastlock = owner_lock;
            keep = (m_locked && owner_lock) || (bus.htrans == HTRANS_BUSY) ||
                   (!m_parked && bus.hbusreq[m_owner] && m_tenure < MAXT - 1);
            if (keep) begin
                m_tenure = sat_inc(m_tenure);
                m_locked = m_locked && owner_lock;
            end else if (owner_lock) begin
                m_locked = 1'b1; m_parked = 1'b0;
                m_tenure = sat_inc(m_tenure);
            end else if (bus.hbusreq != '0) begin
                m_owner  = rr_next(bus.hbusreq, m_owner);
                m_tenure = 0; m_parked = 1'b0; m_locked = 1'b0;
            end else begin
                m_tenure = (m_owner == DEF) ? sat_inc(m_tenure) : 0;
                m_owner  = DEF; m_parked = 1'b1; m_locked = 1'b0;
            end
        end
    end

    // Compare process, half a cycle after each edge.
    always @(negedge hclk) begin
        if (chk_en) begin
            check("model_hgrant",    bus.hgrant, 32'(4'b0001 << m_owner));
            check("model_hmaster",   bus.hmaster, 32'(m_hmaster));
            check("model_hmastlock", bus.hmastlock, 32'(m_hmastlock));
            check("onehot_hgrant",   32'($onehot(bus.hgrant)), 32'd1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    task automatic do_reset();
        hreset      = 1'b1;
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.hready  = 1'b1;
        bus.htrans  = HTRANS_NONSEQ;
        step(1);
        hreset = 1'b0;
    endtask

    int rr_exp [20] = '{1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0,0,0, 1,1,1,1};

    initial begin
        // Reset held for two edges.
        hreset      = 1'b1;
        bus.hbusreq = '0;
        bus.hlock   = '0;
        bus.hready  = 1'b1;
        bus.htrans  = HTRANS_IDLE;
        step(2);
        chk_en = 1'b1;
        check("reset_hgrant",    bus.hgrant, 4'b0001);
        check("reset_hmaster",   bus.hmaster, 0);
        check("reset_hmastlock", bus.hmastlock, 0);
        hreset = 1'b0;

        // Single requester.
        do_reset();
        bus.hbusreq = 4'b0100;
        step(1);
        check("single_hgrant", bus.hgrant, 4'b0100);
        step(1);
        check("single_hmaster", bus.hmaster, 2);

        // Round robin with everyone requesting.
        do_reset();
        bus.hbusreq = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("rr_hgrant", bus.hgrant, 32'(4'b0001 << rr_exp[i]));
        end

        // Stall mid-tenure delays the handover by the stall length.
        do_reset();
        bus.hbusreq = 4'b1111;
        step(2);
        bus.hready = 1'b0;
        step(3);
        check("stall_hgrant_frozen",  bus.hgrant, 4'b0010);
        check("stall_hmaster_frozen", bus.hmaster, 1);
        bus.hready = 1'b1;
        step(2);
        check("stall_hgrant_late", bus.hgrant, 4'b0010);
        step(1);
        check("stall_handover", bus.hgrant, 4'b0100);

        // Locked master 3 against competing requests.
        do_reset();
        bus.hbusreq = 4'b1000;
        bus.hlock   = 4'b1000;
        step(1);
        check("lock_first_grant", bus.hgrant, 4'b1000);
        bus.hbusreq = 4'b1111;
        if (LOCK_EN) begin
            for (int i = 0; i < 20; i++) begin
                step(1);
                check("lock_hgrant",    bus.hgrant, 4'b1000);
                check("lock_hmastlock", bus.hmastlock, 1);
            end
            bus.hlock = '0;
            step(1);
            check("lock_release", bus.hgrant, 4'b0001);
        end else begin
            step(3);
            check("nolock_hgrant_held", bus.hgrant, 4'b1000);
            step(1);
            check("nolock_rotate",    bus.hgrant, 4'b0001);
            check("nolock_hmastlock", bus.hmastlock, 0);
        end

        // Reset mid-tenure restarts from the reset pointer.
        do_reset();
        bus.hbusreq = 4'b0100;
        step(2);
        check("midrst_owner", bus.hgrant, 4'b0100);
        hreset = 1'b1;
        step(1);
        check("midrst_hgrant",  bus.hgrant, 4'b0001);
        check("midrst_hmaster", bus.hmaster, 0);
        hreset      = 1'b0;
        bus.hbusreq = 4'b0110;
        step(1);
        check("midrst_winner", bus.hgrant, 4'b0010);

        // Randomized traffic; the compare process checks every cycle.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            hreset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 2) == 0) bus.hbusreq = N'($urandom);
            if ($urandom_range(0, 7) == 0) bus.hlock = N'($urandom) & N'($urandom);
            bus.hready = ($urandom_range(0, 3) != 0);
            bus.htrans = htrans_t'($urandom_range(0, 3));
            step(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
